// File: rtl/counter_updown_mod_pkg.sv
// Shared definitions for the up/down modulo counter family.
// Holds the mode/direction encodings reused by timer and divider blocks, the
// per-edge operation type and the priority decode that selects it.
package counter_updown_mod_pkg;

  // Count mode encodings (Mode input).
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Count direction encodings (Up input).
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Operation selected on a rising edge.
  typedef enum logic [1:0] {
    OpReset,
    OpLoad,
    OpCount,
    OpHold
  } op_e;

  // Fixed priority: clear, then load, then count, then hold.
  function automatic op_e decode_op(input logic clr, input logic load, input logic enable);
    op_e op;
    if (!clr) begin
      op = OpReset;
    end else if (load) begin
      op = OpLoad;
    end else if (enable) begin
      op = OpCount;
    end else begin
      op = OpHold;
    end
    return op;
  endfunction

endpackage

// File: rtl/counter_updown_mod_next.sv
// Combinational next-count and bound-detect unit for counter_updown_mod.
// Ports:
//   q        - current count
//   up       - direction (1 = increment)
//   mode     - 0 = wrap at the bound, 1 = saturate at the bound
//   next     - count to store if this edge counts
//   wrap     - this step crosses the bound in wrap mode
//   at_bound - q equals the bound in the current direction
module counter_updown_mod_next
  import counter_updown_mod_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  input  logic             mode,
  output logic [WIDTH-1:0] next,
  output logic             wrap,
  output logic             at_bound
);

  // One extra bit so the step past MAX and the borrow below zero are visible.
  localparam logic [WIDTH:0] MaxW = {1'b0, MAX};

  logic [WIDTH:0] q_w;
  logic [WIDTH:0] inc_w;
  logic [WIDTH:0] dec_w;
  logic           out_of_range;

  assign q_w          = {1'b0, q};
  assign inc_w        = q_w + (WIDTH + 1)'(1);
  assign dec_w        = q_w - (WIDTH + 1)'(1);
  assign out_of_range = q_w > MaxW;

  always_comb begin
    next = q;
    wrap = 1'b0;
    if (up == DIR_UP) begin
      if (out_of_range) begin
        // Recover an illegal value straight to the start of the up range.
        next = '0;
      end else if (inc_w > MaxW) begin
        if (mode == MODE_WRAP) begin
          next = '0;
          wrap = 1'b1;
        end else begin
          next = MAX;
        end
      end else begin
        next = inc_w[WIDTH-1:0];
      end
    end else begin
      if (out_of_range) begin
        next = MAX;
      end else if (dec_w[WIDTH]) begin
        // Borrow out of zero.
        if (mode == MODE_WRAP) begin
          next = MAX;
          wrap = 1'b1;
        end else begin
          next = '0;
        end
      end else begin
        next = dec_w[WIDTH-1:0];
      end
    end
  end

  assign at_bound = (up == DIR_UP) ? (q == MAX) : (q == '0);

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised synchronous up/down modulo counter with parallel load,
// wrap/saturate mode and cascade output.
// Ports:
//   Clk      - clock, all state changes on the rising edge
//   Clr      - synchronous active-low clear
//   Enable   - count enable / cascade input from a lower stage's CarryOut
//   Up       - direction, 1 = increment, 0 = decrement
//   Mode     - 0 = wrap, 1 = saturate
//   Load     - parallel load strobe (D is clamped to MODULUS-1)
//   D        - load value
//   Q        - registered count, always within 0..MODULUS-1 once cleared
//   CarryOut - combinational: this stage wraps on the next edge
//   Wrap     - registered one-cycle pulse after a wrap
//   AtLimit  - registered: Q equals the bound for the direction in force at the update
module counter_updown_mod
  import counter_updown_mod_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MODULUS = 2 ** WIDTH
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Enable,
  input  logic             Up,
  input  logic             Mode,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             CarryOut,
  output logic             Wrap,
  output logic             AtLimit
);

  localparam logic [WIDTH-1:0] Max = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             at_limit_q, at_limit_d;

  logic [WIDTH-1:0] cnt_next;
  logic             cnt_wrap;
  logic             cnt_at_bound;
  logic [WIDTH-1:0] load_val;
  op_e              op;

  counter_updown_mod_next #(
    .WIDTH (WIDTH),
    .MAX   (Max)
  ) u_next (
    .q        (q_q),
    .up       (Up),
    .mode     (Mode),
    .next     (cnt_next),
    .wrap     (cnt_wrap),
    .at_bound (cnt_at_bound)
  );

  assign load_val = (D > Max) ? Max : D;
  assign op       = decode_op(Clr, Load, Enable);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    unique case (op)
      OpReset: q_d = '0;
      OpLoad:  q_d = load_val;
      OpCount: begin
        q_d    = cnt_next;
        wrap_d = cnt_wrap;
      end
      OpHold:  q_d = q_q;
      default: q_d = q_q;
    endcase
  end

  // Judged against the direction sampled on this edge, so a direction change
  // shows up in AtLimit one cycle after it is applied.
  assign at_limit_d = (Up == DIR_UP) ? (q_d == Max) : (q_d == '0);

  always_ff @(posedge Clk) begin
    if (!Clr) begin
      q_q        <= '0;
      wrap_q     <= 1'b0;
      at_limit_q <= (Up == DIR_DOWN);
    end else begin
      q_q        <= q_d;
      wrap_q     <= wrap_d;
      at_limit_q <= at_limit_d;
    end
  end

  // Same-cycle cascade enable; load and clear suppress it, saturate never wraps.
  assign CarryOut = Enable & ~Load & Clr & (Mode == MODE_WRAP) & cnt_at_bound;

  assign Q       = q_q;
  assign Wrap    = wrap_q;
  assign AtLimit = at_limit_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod (WIDTH=4, MODULUS=10): a single instance for the
// directed scenarios and a two-stage cascade. Each driven cycle pushes the
// expected visible state into a queue; a monitor pops and compares on negedge.
module tb_counter_updown_mod;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Single instance.
  logic       clr = 1'b0, en = 1'b0, up = 1'b1, mode = 1'b0, load = 1'b0;
  logic [3:0] d = '0;
  logic [3:0] q;
  logic       co, wrap, atl;

  // Cascade pair.
  logic       c_clr = 1'b0, c_en = 1'b0;
  logic [3:0] lo_q, hi_q;
  logic       lo_co, hi_co, lo_wrap, hi_wrap, lo_atl, hi_atl;

  counter_updown_mod #(.WIDTH(4), .MODULUS(10)) dut (
    .Clk(clk), .Clr(clr), .Enable(en), .Up(up), .Mode(mode), .Load(load), .D(d),
    .Q(q), .CarryOut(co), .Wrap(wrap), .AtLimit(atl)
  );

  counter_updown_mod #(.WIDTH(4), .MODULUS(10)) u_lo (
    .Clk(clk), .Clr(c_clr), .Enable(c_en), .Up(1'b1), .Mode(1'b0), .Load(1'b0), .D(4'd0),
    .Q(lo_q), .CarryOut(lo_co), .Wrap(lo_wrap), .AtLimit(lo_atl)
  );

  counter_updown_mod #(.WIDTH(4), .MODULUS(10)) u_hi (
    .Clk(clk), .Clr(c_clr), .Enable(lo_co), .Up(1'b1), .Mode(1'b0), .Load(1'b0), .D(4'd0),
    .Q(hi_q), .CarryOut(hi_co), .Wrap(hi_wrap), .AtLimit(hi_atl)
  );

  typedef struct {
    string      nm;
    bit         ck_st;   // check Q/Wrap/AtLimit
    logic [3:0] q;
    logic       w;
    logic       a;
    bit         ck_co;   // check CarryOut
    logic       co;
    bit         ck_cas;  // check cascade pair
    logic [3:0] lo;
    logic [3:0] hi;
    logic       lco;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.ck_st) begin
          chk({e.nm, ".Q"}, 32'(q), 32'(e.q));
          chk({e.nm, ".Wrap"}, 32'(wrap), 32'(e.w));
          chk({e.nm, ".AtLimit"}, 32'(atl), 32'(e.a));
        end
        if (e.ck_co) chk({e.nm, ".CarryOut"}, 32'(co), 32'(e.co));
        if (e.ck_cas) begin
          chk({e.nm, ".lo"}, 32'(lo_q), 32'(e.lo));
          chk({e.nm, ".hi"}, 32'(hi_q), 32'(e.hi));
          chk({e.nm, ".lo_co"}, 32'(lo_co), 32'(e.lco));
        end
      end
    end
  end

  // Drive one cycle of the single instance; expected values describe the state
  // visible during this cycle and CarryOut for the inputs applied now.
  task automatic step(input logic i_clr, input logic i_en, input logic i_up,
                      input logic i_mode, input logic i_load, input logic [3:0] i_d,
                      input string nm, input bit ck, input logic [3:0] eq,
                      input logic ew, input logic ea, input logic eco);
    exp_t e;
    @(posedge clk);
    #1;
    clr = i_clr; en = i_en; up = i_up; mode = i_mode; load = i_load; d = i_d;
    e = '{nm: nm, ck_st: ck, q: eq, w: ew, a: ea, ck_co: 1'b1, co: eco,
          ck_cas: 1'b0, lo: 4'd0, hi: 4'd0, lco: 1'b0};
    exp_q.push_back(e);
  endtask

  // Drive one cycle of the cascade; n is the number of enabled edges so far.
  task automatic cstep(input logic i_clr, input logic i_en, input bit ck, input int n);
    exp_t e;
    logic [3:0] elo, ehi;
    elo = 4'(n % 10);
    ehi = 4'((n / 10) % 10);
    @(posedge clk);
    #1;
    c_clr = i_clr; c_en = i_en;
    e = '{nm: "cascade", ck_st: 1'b0, q: 4'd0, w: 1'b0, a: 1'b0, ck_co: 1'b0, co: 1'b0,
          ck_cas: ck, lo: elo, hi: ehi, lco: i_en && (elo == 4'd9)};
    exp_q.push_back(e);
  endtask

  initial begin
    logic [3:0] dn_q [5];
    dn_q[0] = 4'd2; dn_q[1] = 4'd1; dn_q[2] = 4'd0; dn_q[3] = 4'd0; dn_q[4] = 4'd0;

    // Reset held two cycles with Enable=1, Up=1.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "rst_a", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "rst_b", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "rst_rel", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, "first_cnt", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);

    // Up wrap from 0.
    for (int j = 0; j < 10; j++)
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "upwrap", 1'b1, 4'(j), 1'b0,
           (j == 9), (j == 9));
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, "upwrap_pulse", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);

    // Down saturate from 2.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, "ld2", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++)
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, "dnsat", 1'b1, dn_q[k], 1'b0,
           (dn_q[k] == 4'd0), 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, "dnsat_end", 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);

    // Load clamp and load-over-enable priority at the bound.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd13, "ld_clamp", 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd9, "ld_pri", 1'b1, 4'd9, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "co_max", 1'b1, 4'd9, 1'b0, 1'b1, 1'b1);

    // Reset mid-count wins over load.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd6, "ld6", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "cnt6", 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5, "rst_mid", 1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "rst_mid_q", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);

    // Reset while counting down leaves AtLimit high; then wrap 0 -> MAX.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "dnwrap_co", 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "dnwrap", 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);

    // Up saturate and a direction change.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd8, "ld8", 1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, "upsat", 1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, "upsat_hold", 1'b1, 4'd9, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "upsat_end", 1'b1, 4'd9, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "dir_chg", 1'b1, 4'd9, 1'b0, 1'b0, 1'b0);

    // Two-stage cascade: 25 enabled edges give {hi,lo} = 2,5.
    cstep(1'b0, 1'b0, 1'b0, 0);
    for (int s = 0; s < 25; s++) cstep(1'b1, 1'b1, 1'b1, s);
    cstep(1'b1, 1'b0, 1'b1, 25);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_updown_mod.md
# counter_updown_mod

Parametrised synchronous up/down modulo counter: the next generation of the T-flip-flop enable-chain counter. It adds count direction, arbitrary modulus, parallel load, a wrap/saturate mode and cascade/terminal-count outputs. It is the general counting primitive for timers, dividers and address generators. Instances can be chained through `CarryOut` to build wider counters.

## Interface
- `WIDTH`, 8, counter width in bits (≥ 2)
- `MODULUS`, 2**WIDTH, count range 0..MODULUS-1 (2 ≤ MODULUS ≤ 2**WIDTH)
- `Clk` input 1: single clock, all state changes on rising edge
- `Clr` input 1: reset, synchronous, active-low
- `Enable` input 1: count enable (also the cascade input from a lower stage's `CarryOut`)
- `Up` input 1: direction, 1 = increment, 0 = decrement
- `Mode` input 1: 0 = wrap, 1 = saturate
- `Load` input 1: parallel load strobe
- `D` input WIDTH: load value
- `Q` output WIDTH: current count, registered
- `CarryOut` output 1: combinational cascade enable, high when this stage will wrap on the next edge
- `Wrap` output 1: registered one-cycle pulse after a wrap occurred
- `AtLimit` output 1: registered, high while `Q` equals the bound in the current direction (MAX = MODULUS-1 if `Up`, 0 otherwise)

## Operation
- Priority on each rising edge: `Clr`=0, then `Load`=1, then `Enable`=1, then hold.
- **Reset** (`Clr`=0):
  - `Q`=0, `Wrap`=0.
  - `AtLimit` = (`Up`==0) evaluated with `Q`=0; i.e. 1 if counting down.
  - Reset is honoured mid-count regardless of `Load`/`Enable`.
- **Load**:
  - `Q` ← `D` if `D` ≤ MAX, else `Q` ← MAX (clamp).
  - `Wrap` = 0 in the following cycle.
  - `Enable` is ignored in a load cycle.
- **Count, wrap mode** (`Mode`=0):
  - Up: `Q`+1, MAX→0.
  - Down: `Q`-1, 0→MAX.
  - Each wrap sets `Wrap`=1 for exactly the next cycle.
- **Count, saturate mode** (`Mode`=1):
  - Up: hold at MAX.
  - Down: hold at 0.
  - `Wrap` never asserts.
- **Width rule:** next-count arithmetic is WIDTH+1 bits internally. No out-of-range value (≥ MODULUS) is ever stored.
- **Out-of-range `Q`:** after power-up before the first reset, `Q` is undefined. Any value > MAX counts to 0 (up) or to MAX (down) on the next enable.
- **Hold:** `Q` is held when `Enable`=0 and `Load`=0. `Wrap` drops to 0.
- **`CarryOut`** = `Enable` & !`Load` & `Clr` & (`Mode`==0) & (`Q` == bound in current direction).
  - Purely combinational from inputs and `Q`.
  - Feeds the `Enable` of the next stage in the same cycle.
- **Direction change:** takes effect on the next edge. `AtLimit` re-evaluates for the new direction one cycle later.

## Timing
- Count latency: 1 cycle from `Enable` sample to new `Q`.
- Load latency: 1 cycle.
- `Wrap` and `AtLimit`: registered, valid in the same cycle as the `Q` they describe.
- `CarryOut`: zero-cycle combinational path; the cascade depth limits Fmax.
- Reset values:
  - `Q`=0
  - `Wrap`=0
  - `AtLimit`=!`Up`
  - `CarryOut` forced 0 while `Clr`=0
- Simultaneous `Load` and `Enable` at the bound: the load wins, and no `Wrap` or `CarryOut` is produced.

## Structure
- Shared header `counter_defs.vh` holds:
  - `MODE_WRAP`=1'b0, `MODE_SAT`=1'b1
  - `DIR_UP`=1'b1, `DIR_DOWN`=1'b0
  - These are reused by timer/divider blocks.
- One natural sub-module, `counter_next`: a combinational next-state and bound-detect unit. It takes `Q`, `Up`, `Mode`, and the MAX parameter. It returns the next count, the wrap flag, and the at-bound flag.
- The top level holds the registers, the priority mux and the `CarryOut` gating.
- Expected RTL size is about 150–250 lines total.

## Test plan
All scenarios use WIDTH=4, MODULUS=10 unless stated.
- **Reset:** `Clr`=0 for 2 cycles with `Enable`=1, `Up`=1 → `Q`=0, `Wrap`=0, `AtLimit`=0, `CarryOut`=0. Release `Clr`; the next edge gives `Q`=1.
- **Up wrap:** `Enable`=1, `Up`=1, `Mode`=0 from 0 for 10 cycles → `Q` runs 1..9,0.
  - `CarryOut`=1 only while `Q`=9.
  - `Wrap`=1 only in the cycle with `Q`=0.
- **Down saturate:** `Load` `D`=2, then `Up`=0, `Mode`=1, `Enable`=1 for 5 cycles → `Q`=1,0,0,0,0.
  - `AtLimit`=1 from the cycle `Q`=0.
  - `Wrap` and `CarryOut` stay 0.
- **Load clamp/priority:** `Load`=1 and `Enable`=1 with `D`=13 → `Q`=9 (clamped), no `Wrap`.
  - Then `Load` `D`=9 with `Enable`=1 and `Q`=9 → `CarryOut`=0, `Q`=9.
- **Reset mid-operation:** counting up at `Q`=7, assert `Clr`=0 together with `Load`=1, `D`=5 → `Q`=0 next cycle.
- **Cascade:** two instances, with the low stage's `CarryOut` driving the high stage's `Enable`, `Enable`=1 for 25 cycles → {hi,lo} = 2,5. The high stage increments only on the edges where lo wraps 9→0.
